// File: rtl/knap_pkg.sv
// Shared types and helpers for the exhaustive knapsack sweep and its evaluator.
package knap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StFin
  } state_e;

  // Wide enough that a sum of n_items coefficients of w bits cannot overflow.
  function automatic int unsigned acc_w(input int unsigned n_items, input int unsigned w);
    return w + $clog2(n_items + 1);
  endfunction

  function automatic int unsigned value_idx(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

  function automatic int unsigned cost_idx(input int unsigned i, input int unsigned d,
                                           input int unsigned n_dims, input int unsigned w);
    return (i * n_dims + d) * w;
  endfunction

  function automatic int unsigned cap_idx(input int unsigned d, input int unsigned w);
    return d * w;
  endfunction

endpackage

// File: rtl/knap_eval.sv
// Combinational evaluation of one selection vector: value sum, per-dimension cost sums and
// feasibility against the minimum value and the capacities.
module knap_eval
  import knap_pkg::*;
#(
  parameter int unsigned N_ITEMS = 5,
  parameter int unsigned N_DIMS  = 2,
  parameter int unsigned W       = 8,
  parameter int unsigned ACC_W   = acc_w(N_ITEMS, W)
) (
  input  logic [N_ITEMS-1:0]        sel,
  input  logic [N_ITEMS*W-1:0]      item_value,
  input  logic [N_ITEMS*N_DIMS*W-1:0] item_cost,
  input  logic [N_DIMS*W-1:0]       capacity,
  input  logic [W-1:0]              min_value,
  output logic [ACC_W-1:0]          value_sum,
  output logic [N_DIMS*ACC_W-1:0]   cost_sum,
  output logic                      feasible
);

  always_comb begin
    value_sum = '0;
    cost_sum  = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (sel[i]) begin
        value_sum = value_sum + ACC_W'(item_value[value_idx(i, W) +: W]);
        for (int unsigned d = 0; d < N_DIMS; d++) begin
          cost_sum[d*ACC_W +: ACC_W] = cost_sum[d*ACC_W +: ACC_W]
                                     + ACC_W'(item_cost[cost_idx(i, d, N_DIMS, W) +: W]);
        end
      end
    end

    feasible = (value_sum >= ACC_W'(min_value));
    for (int unsigned d = 0; d < N_DIMS; d++) begin
      if (cost_sum[d*ACC_W +: ACC_W] > ACC_W'(capacity[cap_idx(d, W) +: W])) begin
        feasible = 1'b0;
      end
    end
  end

endmodule

// File: rtl/knapsack_sweep.sv
// Exhaustive knapsack solver: sweeps every selection vector through a two-stage
// evaluate/compare pipeline and reports the best feasible selection.
module knapsack_sweep
  import knap_pkg::*;
#(
  parameter int unsigned N_ITEMS = 5,
  parameter int unsigned N_DIMS  = 2,
  parameter int unsigned W       = 8,
  parameter int unsigned ACC_W   = acc_w(N_ITEMS, W)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [W-1:0]                min_value,
  input  logic [N_DIMS*W-1:0]         capacity,
  input  logic [N_ITEMS*W-1:0]        item_value,
  input  logic [N_ITEMS*N_DIMS*W-1:0] item_cost,
  output logic                        busy,
  output logic                        done,
  output logic                        best_valid,
  output logic [N_ITEMS-1:0]          best_sel,
  output logic [ACC_W-1:0]            best_value,
  output logic [N_ITEMS:0]            feasible_count
);

  localparam logic [N_ITEMS:0] LastSel = (N_ITEMS + 1)'((1 << N_ITEMS) - 1);

  state_e state;

  logic [N_ITEMS*W-1:0]        snap_value;
  logic [N_ITEMS*N_DIMS*W-1:0] snap_cost;
  logic [N_DIMS*W-1:0]         snap_cap;
  logic [W-1:0]                snap_min;
  logic [N_ITEMS:0]            cnt;

  logic                        s1_valid;
  logic                        s1_feasible;
  logic [N_ITEMS-1:0]          s1_sel;
  logic [ACC_W-1:0]            s1_value;

  logic [ACC_W-1:0]            eval_value;
  logic [N_DIMS*ACC_W-1:0]     eval_cost;
  logic                        eval_feasible;

  knap_eval #(
    .N_ITEMS (N_ITEMS),
    .N_DIMS  (N_DIMS),
    .W       (W),
    .ACC_W   (ACC_W)
  ) u_eval (
    .sel        (cnt[N_ITEMS-1:0]),
    .item_value (snap_value),
    .item_cost  (snap_cost),
    .capacity   (snap_cap),
    .min_value  (snap_min),
    .value_sum  (eval_value),
    .cost_sum   (eval_cost),
    .feasible   (eval_feasible)
  );

  // Cost sums only matter here through the feasible flag.
  logic unused_cost;
  assign unused_cost = ^eval_cost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      busy           <= 1'b0;
      done           <= 1'b0;
      best_valid     <= 1'b0;
      best_sel       <= '0;
      best_value     <= '0;
      feasible_count <= '0;
      snap_value     <= '0;
      snap_cost      <= '0;
      snap_cap       <= '0;
      snap_min       <= '0;
      cnt            <= '0;
      s1_valid       <= 1'b0;
      s1_feasible    <= 1'b0;
      s1_sel         <= '0;
      s1_value       <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= 1'b0;

      unique case (state)
        StIdle: begin
          if (start) begin
            snap_value     <= item_value;
            snap_cost      <= item_cost;
            snap_cap       <= capacity;
            snap_min       <= min_value;
            cnt            <= '0;
            busy           <= 1'b1;
            best_valid     <= 1'b0;
            best_sel       <= '0;
            best_value     <= '0;
            feasible_count <= '0;
            state          <= StSweep;
          end
        end
        StSweep: begin
          s1_valid    <= 1'b1;
          s1_sel      <= cnt[N_ITEMS-1:0];
          s1_value    <= eval_value;
          s1_feasible <= eval_feasible;
          cnt         <= cnt + (N_ITEMS + 1)'(1);
          if (cnt == LastSel) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (!s1_valid) begin
            state <= StFin;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        StFin: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase

      // Strict greater-than keeps the lower-index selection on ties.
      if (s1_valid && s1_feasible) begin
        feasible_count <= feasible_count + (N_ITEMS + 1)'(1);
        if (!best_valid || (s1_value > best_value)) begin
          best_valid <= 1'b1;
          best_sel   <= s1_sel;
          best_value <= s1_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_knapsack_sweep.sv
// Directed and randomized checks of knapsack_sweep against a brute-force reference model.
module tb_knapsack_sweep;

  localparam int N  = 5;
  localparam int D  = 2;
  localparam int W  = 8;
  localparam int AW = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     min_value = '0;
  logic [D*W-1:0]   capacity = '0;
  logic [N*W-1:0]   item_value = '0;
  logic [N*D*W-1:0] item_cost = '0;
  logic             busy;
  logic             done;
  logic             best_valid;
  logic [N-1:0]     best_sel;
  logic [AW-1:0]    best_value;
  logic [N:0]       feasible_count;

  int vals[N];
  int cst[N][D];
  int cap[D];
  int minv;
  int n_checks = 0;
  int n_fail = 0;
  int lat;

  knapsack_sweep #(
    .N_ITEMS (N),
    .N_DIMS  (D),
    .W       (W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .min_value      (min_value),
    .capacity       (capacity),
    .item_value     (item_value),
    .item_cost      (item_cost),
    .busy           (busy),
    .done           (done),
    .best_valid     (best_valid),
    .best_sel       (best_sel),
    .best_value     (best_value),
    .feasible_count (feasible_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      item_value[i*W +: W] = W'(vals[i]);
      for (int d = 0; d < D; d++) item_cost[(i*D+d)*W +: W] = W'(cst[i][d]);
    end
    for (int d = 0; d < D; d++) capacity[d*W +: W] = W'(cap[d]);
    min_value = W'(minv);
  endtask

  task automatic set_baseline();
    int bv[N] = '{4, 2, 2, 1, 10};
    int b0[N] = '{12, 1, 2, 1, 4};
    int b1[N] = '{10, 2, 1, 4, 3};
    for (int i = 0; i < N; i++) begin
      vals[i] = bv[i];
      cst[i][0] = b0[i];
      cst[i][1] = b1[i];
    end
    cap[0] = 16;
    cap[1] = 10;
    minv = 15;
  endtask

  // Brute force over every subset, straight from the problem definition.
  task automatic model(output int v, output int s, output int bv, output int fc);
    v = 0; s = 0; bv = 0; fc = 0;
    for (int m = 0; m < (1 << N); m++) begin
      int vs;
      bit ok;
      vs = 0;
      for (int i = 0; i < N; i++) if (m[i]) vs += vals[i];
      ok = (vs >= minv);
      for (int d = 0; d < D; d++) begin
        int cs;
        cs = 0;
        for (int i = 0; i < N; i++) if (m[i]) cs += cst[i][d];
        if (cs > cap[d]) ok = 1'b0;
      end
      if (ok) begin
        fc++;
        if (v == 0 || vs > bv) begin
          v = 1; s = m; bv = vs;
        end
      end
    end
  endtask

  task automatic check_results(input string tag, input int v, input int s, input int bv,
                               input int fc);
    check({tag, ".best_valid"}, 32'(best_valid), v);
    check({tag, ".best_sel"}, 32'(best_sel), s);
    check({tag, ".best_value"}, 32'(best_value), bv);
    check({tag, ".feasible_count"}, 32'(feasible_count), fc);
  endtask

  // Starts a sweep and measures the done latency from the accepting edge.
  task automatic run(input string tag, input bit poke, input bit scramble, input int abort_at,
                     output int latency);
    int seen;
    latency = -1;
    @(negedge clk);
    drive();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, ".busy_after_start"}, 32'(busy), 1);
    if (scramble) begin
      item_value = (N*W)'({$urandom(), $urandom()});
      item_cost  = (N*D*W)'({$urandom(), $urandom(), $urandom()});
      capacity   = (D*W)'($urandom());
      min_value  = W'($urandom());
    end
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (poke && k == 5) start = 1'b1;
      if (poke && k == 6) start = 1'b0;
      if (abort_at == k) begin
        rst_n = 1'b0;
        #1;
        check({tag, ".abort_busy"}, 32'(busy), 0);
        check({tag, ".abort_done"}, 32'(done), 0);
        check_results({tag, ".abort"}, 0, 0, 0, 0);
        seen = 0;
        repeat (40) begin
          @(posedge clk);
          #1 if (done) seen++;
        end
        check({tag, ".abort_no_done"}, seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        latency = k;
        break;
      end
    end
    check({tag, ".latency"}, latency, 34);
    check({tag, ".busy_at_done"}, 32'(busy), 0);
    @(posedge clk);
    #1 check({tag, ".done_width"}, 32'(done), 0);
  endtask

  initial begin
    int mv, ms, mbv, mfc;
    #12;
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    check_results("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    set_baseline();
    run("base", 1'b1, 1'b1, 0, lat);
    check_results("base", 1, 'h1E, 15, 1);
    repeat (5) @(posedge clk);
    #1 check_results("base_hold", 1, 'h1E, 15, 1);

    set_baseline();
    minv = 0; cap[0] = 255; cap[1] = 255;
    run("allfeas", 1'b0, 1'b0, 0, lat);
    check_results("allfeas", 1, 'h1F, 19, 32);

    set_baseline();
    minv = 20;
    run("none", 1'b0, 1'b0, 0, lat);
    check_results("none", 0, 0, 0, 0);

    for (int i = 0; i < N; i++) begin
      vals[i] = (i < 2) ? 3 : 0;
      cst[i][0] = (i < 2) ? 1 : 0;
      cst[i][1] = 0;
    end
    cap[0] = 1; cap[1] = 255; minv = 3;
    run("tie", 1'b0, 1'b0, 0, lat);
    check_results("tie", 1, 'h01, 3, 16);

    set_baseline();
    run("abort", 1'b0, 1'b0, 10, lat);
    run("after_abort", 1'b0, 1'b0, 0, lat);
    check_results("after_abort", 1, 'h1E, 15, 1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        vals[i] = $urandom_range(0, 120);
        for (int d = 0; d < D; d++) cst[i][d] = $urandom_range(0, 100);
      end
      for (int d = 0; d < D; d++) cap[d] = $urandom_range(0, 255);
      minv = $urandom_range(0, 255);
      model(mv, ms, mbv, mfc);
      run($sformatf("rand%0d", t), 1'b0, 1'b1, 0, lat);
      check_results($sformatf("rand%0d", t), mv, ms, mbv, mfc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knapsack_sweep.md
Name: knapsack_sweep

Overview:
- Parametrised exhaustive knapsack solver. Snapshots N_ITEMS item coefficients and N_DIMS cost capacities on start.
- Sweeps all 2^N_ITEMS selection vectors, one per cycle, through a 2-stage evaluate/compare pipeline.
- Reports the best feasible selection, its value and the count of feasible selections.
- Sits behind the problem-loader as the reference answer generator for the annealer comparison flow.

Parameters:
- N_ITEMS, 5, number of items; selection vector width; sweep length 2^N_ITEMS.
- N_DIMS, 2, number of cost dimensions (e.g. weight, volume).
- W, 8, width of every coefficient, capacity and min_value.
- ACC_W, W+$clog2(N_ITEMS+1), sum width; sums never overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; honoured only when busy=0.
- min_value  in  W  required minimum total value.
- capacity  in  N_DIMS*W  per-dimension capacity; dim d at [d*W +: W].
- item_value  in  N_ITEMS*W  value of item i at [i*W +: W].
- item_cost  in  N_ITEMS*N_DIMS*W  cost of item i, dim d at [(i*N_DIMS+d)*W +: W].
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse; results final.
- best_valid  out  1  at least one feasible selection found.
- best_sel  out  N_ITEMS  best selection; bit i = item i chosen.
- best_value  out  ACC_W  total value of best_sel.
- feasible_count  out  N_ITEMS+1  number of feasible selections.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; busy=0, done=0, best_valid=0, best_sel=0, best_value=0, feasible_count=0; pipeline valids cleared.
- Reset mid-sweep aborts immediately. No done pulse is produced.
- FSM states: IDLE, SWEEP, DRAIN, FIN.
- IDLE: start=1 at edge E0:
  - snapshot all coefficient, capacity and min_value inputs into internal registers;
  - clear results; cnt=0; busy=1; go to SWEEP.
  - Inputs may change freely after E0.
- SWEEP: each edge registers stage-1 data (sel=cnt, value sum, N_DIMS cost sums) and increments cnt.
  - After issuing cnt = 2^N_ITEMS-1, go to DRAIN.
  - cnt is N_ITEMS+1 bits wide; no wrap inside a sweep.
- Feasible: value sum >= min_value AND every cost sum[d] <= capacity[d]. All comparisons unsigned, at ACC_W bits.
- Stage 2, on each valid stage-1 entry that is feasible:
  - feasible_count += 1.
  - Replace best when best_valid=0 or value > best_value.
  - Ties keep the earlier (lower-index) selection.
- DRAIN: wait for the pipeline to empty, then go to FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
- Timing: done is high in the cycle after edge E0+2^N_ITEMS+2.
- Results hold until the next accepted start.
- start while busy=1 is ignored. start in the FIN cycle is ignored. start is accepted again from IDLE.
- No feasible selection: best_valid=0, best_sel=0, best_value=0, feasible_count=0.
- All-feasible: feasible_count = 2^N_ITEMS, which requires the N_ITEMS+1 width.

Decomposition:
- Package knap_pkg holds:
  - state enum (IDLE, SWEEP, DRAIN, FIN);
  - function acc_w(n_items, w);
  - index helper functions for the flattened coefficient buses.
- One combinational sub-module, knap_eval. Given the selection vector and the snapshots it returns the value sum, the cost sums and a feasible flag. It is reusable by the annealer checker.

Test Plan:
- Baseline: values {4,2,2,1,10}, dim0 costs {12,1,2,1,4}, dim1 costs {10,2,1,4,3}, capacity {16,10}, min_value 15. Required: best_valid=1, best_sel=5'h1E, best_value=15, feasible_count=1.
- min_value 0, capacities {255,255}, baseline coefficients. Required: feasible_count=32, best_sel=5'h1F, best_value=19.
- min_value 20, baseline coefficients. Required: best_valid=0, best_sel=0, best_value=0, feasible_count=0, done still pulses.
- Tie case: values {3,3,0,0,0}, dim0 costs {1,1,0,0,0}, capacity {1,255}, min_value 3. Required: best_sel=5'h01, best_value=3, feasible_count=16.
- Timing and start handling:
  - done rises exactly 34 cycles after the start edge, high for 1 cycle;
  - a start pulse at cycle 5 of the sweep is ignored;
  - coefficients changed after E0 do not affect the baseline result.
- Drop rst_n at cycle 10 of a sweep. Required: all outputs 0 asynchronously and no done pulse. A following start reproduces the baseline result.
